nasti_sram_bridge: RTL and testbench

NASTI slave endpoint that serves the combined read/write port produced by the read/write combiner, translating AR/R and AW/W/B bursts into accesses on a single-port synchronous SRAM. Only one transaction is in flight at a time. Reads and writes arbitrate round-robin. INCR and FIXED bursts of any length and size are executed beat by beat.

---
 rtl/nasti_sram_bridge_if.sv | 86 ++++++++
 rtl/nasti_sram_bridge.sv | 230 +++++++++++++++++++++++
 tb/tb_nasti_sram_bridge.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_sram_bridge_if.sv
// NASTI channel bundle (AW, W, B, AR, R) with master and slave views.
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/nasti_sram_bridge.sv
// NASTI slave onto a single-port synchronous SRAM: one burst in flight, round-robin read/write.
// Define NASTI_SRAM_BRIDGE_ERR_EN to answer bursts starting beyond the SRAM with DECERR.
module nasti_sram_bridge #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int MEM_AW     = 16
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    nasti_channel.slave                            nasti,
    output logic                                   sram_en,
    output logic                                   sram_we,
    output logic [MEM_AW-$clog2(DATA_WIDTH/8)-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]                  sram_wdata,
    output logic [DATA_WIDTH/8-1:0]                sram_be,
    input  logic [DATA_WIDTH-1:0]                  sram_rdata
);
    localparam int         OFF_W       = $clog2(DATA_WIDTH/8);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_run;
    logic                  r_last_wr;
    logic [ID_WIDTH-1:0]   r_id_cap;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;

    logic                  w_err;
    logic                  w_grant_rd;
    logic                  w_grant_wr;
    logic                  w_ar_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_b_hs;
    logic                  w_rlast;
    logic [ADDR_WIDTH-1:0] w_addr_step;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_unused_ok;

    // r_last_wr remembers the last served direction so a tie goes the other way
    assign w_grant_rd  = nasti.ar_valid & (~nasti.aw_valid | r_last_wr);
    assign w_grant_wr  = nasti.aw_valid & (~nasti.ar_valid | ~r_last_wr);
    assign w_ar_hs     = r_run & (r_state == ST_IDLE) & w_grant_rd;
    assign w_aw_hs     = r_run & (r_state == ST_IDLE) & w_grant_wr;
    assign w_w_hs      = (r_state == ST_WR_DATA) & nasti.w_valid;
    assign w_r_hs      = (r_state == ST_RD_DATA) & nasti.r_ready;
    assign w_b_hs      = (r_state == ST_WR_RESP) & nasti.b_ready;
    assign w_rlast     = (r_cnt == r_len);
    assign w_addr_step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << r_size;
    assign w_addr_nxt  = (r_burst == BURST_FIXED) ? r_addr : (r_addr + w_addr_step);
    assign sram_addr   = r_addr[MEM_AW-1:OFF_W];

    assign w_unused_ok = ^{nasti.aw_len, nasti.aw_lock, nasti.aw_cache, nasti.aw_prot,
                           nasti.aw_qos, nasti.aw_region, nasti.aw_user, nasti.w_user,
                           nasti.ar_lock, nasti.ar_cache, nasti.ar_prot, nasti.ar_qos,
                           nasti.ar_region, nasti.ar_user};

`ifdef NASTI_SRAM_BRIDGE_ERR_EN
    logic r_err;
    logic w_ar_oor;
    logic w_aw_oor;

    assign w_ar_oor = |(nasti.ar_addr >> MEM_AW);
    assign w_aw_oor = |(nasti.aw_addr >> MEM_AW);

    // Out-of-range flag captured with the burst start address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_ar_hs) begin
            r_err <= w_ar_oor;
        end else if (w_aw_hs) begin
            r_err <= w_aw_oor;
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst context: captured at AR/AW accept, advanced per beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run     <= 1'b0;
            r_last_wr <= 1'b1;
            r_id_cap  <= {ID_WIDTH{1'b0}};
            r_addr    <= {ADDR_WIDTH{1'b0}};
            r_len     <= 8'd0;
            r_cnt     <= 8'd0;
            r_size    <= 3'd0;
            r_burst   <= 2'd0;
        end else begin
            r_run <= 1'b1;
            if (w_ar_hs) begin
                r_id_cap  <= nasti.ar_id;
                r_addr    <= nasti.ar_addr;
                r_len     <= nasti.ar_len;
                r_size    <= nasti.ar_size;
                r_burst   <= nasti.ar_burst;
                r_cnt     <= 8'd0;
                r_last_wr <= 1'b0;
            end else if (w_aw_hs) begin
                r_id_cap  <= nasti.aw_id;
                r_addr    <= nasti.aw_addr;
                r_size    <= nasti.aw_size;
                r_burst   <= nasti.aw_burst;
                r_cnt     <= 8'd0;
                r_last_wr <= 1'b1;
            end else if (w_r_hs & ~w_rlast) begin
                r_addr <= w_addr_nxt;
                r_cnt  <= r_cnt + 8'd1;
            end else if (w_w_hs) begin
                r_addr <= w_addr_nxt;
            end
        end
    end

    // Next state and all bus/SRAM outputs decoded from state
    always_comb begin
        w_state_nxt    = r_state;
        nasti.ar_ready = 1'b0;
        nasti.aw_ready = 1'b0;
        nasti.w_ready  = 1'b0;
        nasti.r_valid  = 1'b0;
        nasti.r_id     = {ID_WIDTH{1'b0}};
        nasti.r_data   = {DATA_WIDTH{1'b0}};
        nasti.r_resp   = RESP_OKAY;
        nasti.r_last   = 1'b0;
        nasti.r_user   = {USER_WIDTH{1'b0}};
        nasti.b_valid  = 1'b0;
        nasti.b_id     = {ID_WIDTH{1'b0}};
        nasti.b_resp   = RESP_OKAY;
        nasti.b_user   = {USER_WIDTH{1'b0}};
        sram_en        = 1'b0;
        sram_we        = 1'b0;
        sram_wdata     = {DATA_WIDTH{1'b0}};
        sram_be        = {(DATA_WIDTH/8){1'b0}};
        case (r_state)
            ST_IDLE: begin
                nasti.ar_ready = w_ar_hs;
                nasti.aw_ready = w_aw_hs;
                if (w_ar_hs) begin
                    w_state_nxt = ST_RD_REQ;
                end else if (w_aw_hs) begin
                    w_state_nxt = ST_WR_DATA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                sram_en     = ~w_err;
                w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // sram_rdata is held by the SRAM until the next strobe, so it drives R directly
                nasti.r_valid = 1'b1;
                nasti.r_id    = r_id_cap;
                nasti.r_last  = w_rlast;
                if (w_err) begin
                    nasti.r_data = {DATA_WIDTH{1'b0}};
                    nasti.r_resp = RESP_DECERR;
                end else begin
                    nasti.r_data = sram_rdata;
                    nasti.r_resp = RESP_OKAY;
                end
                if (w_r_hs) begin
                    w_state_nxt = w_rlast ? ST_IDLE : ST_RD_REQ;
                end else begin
                    w_state_nxt = ST_RD_DATA;
                end
            end
            ST_WR_DATA: begin
                nasti.w_ready = 1'b1;
                if (w_w_hs & ~w_err) begin
                    sram_en    = 1'b1;
                    sram_we    = 1'b1;
                    sram_wdata = nasti.w_data;
                    sram_be    = nasti.w_strb;
                end else begin
                    sram_en = 1'b0;
                end
                if (w_w_hs & nasti.w_last) begin
                    w_state_nxt = ST_WR_RESP;
                end else begin
                    w_state_nxt = ST_WR_DATA;
                end
            end
            ST_WR_RESP: begin
                nasti.b_valid = 1'b1;
                nasti.b_id    = r_id_cap;
                nasti.b_resp  = w_err ? RESP_DECERR : RESP_OKAY;
                if (w_b_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_nasti_sram_bridge.sv
// Directed bench for nasti_sram_bridge with a behavioural SRAM (32 words x 64 bits).
module tb_nasti_sram_bridge;
    localparam int IDW = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int UW  = 1;
    localparam int MAW = 8;

    logic        clk;
    logic        rstn;
    logic        sram_en;
    logic        sram_we;
    logic [4:0]  sram_addr;
    logic [63:0] sram_wdata;
    logic [7:0]  sram_be;
    logic [63:0] sram_rdata;
    logic [63:0] mem [0:31];
    logic        preload;
    int          n_assert = 0;
    int          n_fail   = 0;

    nasti_channel #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

    nasti_sram_bridge #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MEM_AW(MAW)
    ) dut (
        .clk(clk), .rstn(rstn), .nasti(bus),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_be(sram_be), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: synchronous read, byte-enabled write, read data held between strobes
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 2) ? 64'h0000_0000_0000_DEAD : 64'd0;
            sram_rdata <= 64'd0;
        end else if (sram_en) begin
            if (sram_we) begin
                for (int k = 0; k < 8; k++)
                    if (sram_be[k]) mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        preload = 1'b1;
        rstn    = 1'b0;
        bus.aw_id = 2'd2; bus.aw_addr = 32'h0; bus.aw_len = 8'd3; bus.aw_size = 3'd3;
        bus.aw_burst = 2'd1; bus.aw_lock = 1'b0; bus.aw_cache = 4'd0; bus.aw_prot = 3'd0;
        bus.aw_qos = 4'd0; bus.aw_region = 4'd0; bus.aw_user = 1'b0; bus.aw_valid = 1'b1;
        bus.w_data = 64'd0; bus.w_strb = 8'h00; bus.w_last = 1'b0; bus.w_user = 1'b0;
        bus.w_valid = 1'b0; bus.b_ready = 1'b0;
        bus.ar_id = 2'd1; bus.ar_addr = 32'h10; bus.ar_len = 8'd0; bus.ar_size = 3'd3;
        bus.ar_burst = 2'd1; bus.ar_lock = 1'b0; bus.ar_cache = 4'd0; bus.ar_prot = 3'd0;
        bus.ar_qos = 4'd0; bus.ar_region = 4'd0; bus.ar_user = 1'b0; bus.ar_valid = 1'b1;
        bus.r_ready = 1'b1;
        repeat (3) tick();
        preload = 1'b0;
        #1;
        chk("rst_ar_ready", bus.ar_ready, 1'b0);
        chk("rst_aw_ready", bus.aw_ready, 1'b0);
        chk("rst_w_ready", bus.w_ready, 1'b0);
        chk("rst_r_valid", bus.r_valid, 1'b0);
        chk("rst_b_valid", bus.b_valid, 1'b0);
        chk("rst_sram_en_we", {sram_en, sram_we}, 2'b00);
        chk("rst_r_payload", {bus.r_data, bus.r_id, bus.r_resp, bus.r_last}, 69'd0);
        chk("rst_b_payload", {bus.b_id, bus.b_resp}, 4'd0);
        chk("rst_sram_bus", {sram_addr, sram_wdata, sram_be}, 77'd0);
        rstn = 1'b1;

        // Both requests pending out of reset: read goes first
        tick(); #1;
        for (int g = 0; g < 8; g++) begin
            if (bus.ar_ready || bus.aw_ready) break;
            tick(); #1;
        end
        chk("arb1_ar_ready", bus.ar_ready, 1'b1);
        chk("arb1_aw_ready", bus.aw_ready, 1'b0);
        tick();
        bus.ar_id = 2'd3; bus.ar_addr = 32'h0; bus.ar_len = 8'd3;
        #1;
        chk("rd1_req_en", {sram_en, sram_we}, 2'b10);
        chk("rd1_req_addr", sram_addr, 5'd2);
        chk("rd1_req_rvalid", bus.r_valid, 1'b0);
        tick(); #1;
        chk("rd1_rvalid", bus.r_valid, 1'b1);
        chk("rd1_rdata", bus.r_data, 64'hDEAD);
        chk("rd1_rlast", bus.r_last, 1'b1);
        chk("rd1_rresp", bus.r_resp, 2'd0);
        chk("rd1_rid", bus.r_id, 2'd1);
        tick(); #1;
        chk("arb2_aw_ready", bus.aw_ready, 1'b1);
        chk("arb2_ar_ready", bus.ar_ready, 1'b0);

        // INCR write burst 1..4 to words 0..3, one idle W cycle in the middle
        tick();
        bus.aw_id = 2'd1; bus.aw_addr = 32'h8; bus.aw_len = 8'd1; bus.aw_burst = 2'd0;
        bus.w_valid = 1'b1; bus.w_data = 64'd1; bus.w_strb = 8'hFF; bus.w_last = 1'b0;
        #1;
        chk("wr1_w_ready", bus.w_ready, 1'b1);
        chk("wr1_en_we", {sram_en, sram_we}, 2'b11);
        chk("wr1_b0_addr", sram_addr, 5'd0);
        chk("wr1_b0_wdata", sram_wdata, 64'd1);
        chk("wr1_b0_be", sram_be, 8'hFF);
        chk("wr1_ar_blocked", bus.ar_ready, 1'b0);
        tick(); bus.w_data = 64'd2; #1;
        chk("wr1_b1_addr", sram_addr, 5'd1);
        chk("wr1_b1_wdata", sram_wdata, 64'd2);
        tick(); bus.w_valid = 1'b0; #1;
        chk("wr1_gap_en", sram_en, 1'b0);
        chk("wr1_gap_w_ready", bus.w_ready, 1'b1);
        tick(); bus.w_valid = 1'b1; bus.w_data = 64'd3; #1;
        chk("wr1_b2_addr", sram_addr, 5'd2);
        tick(); bus.w_data = 64'd4; bus.w_last = 1'b1; #1;
        chk("wr1_b3_addr", sram_addr, 5'd3);
        chk("wr1_b3_en", sram_en, 1'b1);
        tick(); bus.w_valid = 1'b0; bus.w_last = 1'b0; #1;
        chk("wr1_bvalid", bus.b_valid, 1'b1);
        chk("wr1_bid", bus.b_id, 2'd2);
        chk("wr1_bresp", bus.b_resp, 2'd0);
        chk("wr1_resp_idle", {bus.w_ready, sram_en}, 2'b00);
        tick(); #1;
        chk("wr1_bvalid_held", bus.b_valid, 1'b1);
        chk("wr1_bid_held", bus.b_id, 2'd2);
        bus.b_ready = 1'b1;
        tick(); bus.b_ready = 1'b0; #1;
        chk("arb3_ar_ready", bus.ar_ready, 1'b1);
        chk("arb3_aw_ready", bus.aw_ready, 1'b0);
        chk("wr1_mem", {mem[3][7:0], mem[2][7:0], mem[1][7:0], mem[0][7:0]}, 32'h04030201);

        // 4-beat read back with r_ready low for 3 cycles on beat 1
        tick(); bus.ar_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            int hold;
            hold = (b == 1) ? 3 : 0;
            #1;
            chk("rd2_req_en", sram_en, 1'b1);
            chk("rd2_req_addr", sram_addr, b);
            tick();
            for (int h = 0; h <= hold; h++) begin
                bus.r_ready = (h == hold);
                #1;
                chk("rd2_rvalid", bus.r_valid, 1'b1);
                chk("rd2_rdata", bus.r_data, b + 1);
                chk("rd2_rlast", bus.r_last, b == 3);
                chk("rd2_rid", bus.r_id, 2'd3);
                chk("rd2_no_en", sram_en, 1'b0);
                tick();
            end
        end
        #1;
        chk("arb4_aw_ready", bus.aw_ready, 1'b1);
        chk("arb4_ar_ready", bus.ar_ready, 1'b0);

        // FIXED two-beat write to word 1 with complementary strobes
        tick();
        bus.aw_valid = 1'b0;
        bus.w_valid = 1'b1; bus.w_data = 64'h1111_1111_2222_2222; bus.w_strb = 8'h0F;
        #1;
        chk("fx_b0_addr", sram_addr, 5'd1);
        chk("fx_b0_be", sram_be, 8'h0F);
        tick();
        bus.w_data = 64'h3333_3333_4444_4444; bus.w_strb = 8'hF0; bus.w_last = 1'b1;
        #1;
        chk("fx_b1_addr", sram_addr, 5'd1);
        chk("fx_b1_be", sram_be, 8'hF0);
        tick(); bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.b_ready = 1'b1; #1;
        chk("fx_bvalid", bus.b_valid, 1'b1);
        chk("fx_bid", bus.b_id, 2'd1);
        tick(); bus.b_ready = 1'b0; #1;
        chk("fx_mem1", mem[1], 64'h3333_3333_2222_2222);
        chk("fx_mem2", mem[2], 64'd3);

        // Reset during beat 1 of a 4-beat read
        bus.ar_valid = 1'b1; bus.ar_id = 2'd2; bus.ar_addr = 32'h0; bus.ar_len = 8'd3;
        #1;
        chk("rr_ar_ready", bus.ar_ready, 1'b1);
        tick(); bus.ar_valid = 1'b0;
        tick();
        tick();
        tick(); #1;
        chk("rr_b1_rvalid", bus.r_valid, 1'b1);
        chk("rr_b1_rdata", bus.r_data, 64'h3333_3333_2222_2222);
        rstn = 1'b0;
        #1;
        chk("rr_async_rvalid", bus.r_valid, 1'b0);
        chk("rr_async_payload", {bus.r_data, bus.r_id, bus.r_last}, 67'd0);
        chk("rr_async_en", sram_en, 1'b0);
        tick(); #1;
        chk("rr_hold_rvalid", bus.r_valid, 1'b0);
        rstn = 1'b1;
        bus.ar_valid = 1'b1; bus.ar_id = 2'd1; bus.ar_addr = 32'h18; bus.ar_len = 8'd0;
        tick(); #1;
        for (int g = 0; g < 8; g++) begin
            if (bus.ar_ready) break;
            tick(); #1;
        end
        chk("pr_ar_ready", bus.ar_ready, 1'b1);
        tick(); bus.ar_valid = 1'b0; #1;
        chk("pr_req_addr", sram_addr, 5'd3);
        chk("pr_req_en", sram_en, 1'b1);
        tick(); #1;
        chk("pr_rdata", bus.r_data, 64'd4);
        chk("pr_rlast", bus.r_last, 1'b1);
        chk("pr_rid", bus.r_id, 2'd1);
        chk("pr_mem_kept", mem[0], 64'd1);
        tick();

`ifdef NASTI_SRAM_BRIDGE_ERR_EN
        bus.ar_valid = 1'b1; bus.ar_id = 2'd0; bus.ar_addr = 32'h100; bus.ar_len = 8'd0;
        #1;
        chk("err_ar_ready", bus.ar_ready, 1'b1);
        tick(); bus.ar_valid = 1'b0; #1;
        chk("err_no_en", sram_en, 1'b0);
        tick(); #1;
        chk("err_rvalid", bus.r_valid, 1'b1);
        chk("err_rresp", bus.r_resp, 2'd3);
        chk("err_rdata", bus.r_data, 64'd0);
        chk("err_rlast", bus.r_last, 1'b1);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
